// File: rtl/data_bus_demux.sv
// Address-decoding demultiplexer from one req/gnt/rvalid data master to NumSlaves regions.
// Keeps responses in order by only letting one target have transactions in flight at a time.
module data_bus_demux #(
  parameter int NumSlaves      = 3,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2,
  parameter logic [NumSlaves*AddrWidth-1:0] SlaveBase = '0,
  parameter logic [NumSlaves*AddrWidth-1:0] SlaveMask = '0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   m_req_i,
  output logic                                   m_gnt_o,
  input  logic [AddrWidth-1:0]                   m_addr_i,
  input  logic                                   m_we_i,
  input  logic [DataWidth/8-1:0]                 m_be_i,
  input  logic [DataWidth-1:0]                   m_wdata_i,
  output logic                                   m_rvalid_o,
  output logic [DataWidth-1:0]                   m_rdata_o,
  output logic                                   m_err_o,
  output logic [NumSlaves-1:0]                   s_req_o,
  output logic [NumSlaves*AddrWidth-1:0]         s_addr_o,
  output logic                                   s_we_o,
  output logic [DataWidth/8-1:0]                 s_be_o,
  output logic [DataWidth-1:0]                   s_wdata_o,
  input  logic [NumSlaves-1:0]                   s_gnt_i,
  input  logic [NumSlaves-1:0]                   s_rvalid_i,
  input  logic [NumSlaves*DataWidth-1:0]         s_rdata_i,
  input  logic [NumSlaves-1:0]                   s_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o
);

  localparam int TgtW = $clog2(NumSlaves + 1);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  // Target index NumSlaves stands for the internal error responder.
  localparam logic [TgtW-1:0] ErrTgt = TgtW'(NumSlaves);

  logic [TgtW-1:0] tgt;
  logic [TgtW-1:0] cur_tgt;
  logic [CntW-1:0] cnt;
  logic            err_pending;
  logic            allowed;

  assign s_we_o        = m_we_i;
  assign s_be_o        = m_be_i;
  assign s_wdata_o     = m_wdata_i;
  assign outstanding_o = cnt;

  for (genvar g = 0; g < NumSlaves; g++) begin : g_local_addr
    assign s_addr_o[g*AddrWidth +: AddrWidth] =
      m_addr_i - SlaveBase[g*AddrWidth +: AddrWidth];
  end

  // Scan from the top so the lowest-indexed overlapping region wins.
  always_comb begin
    tgt = ErrTgt;
    for (int i = NumSlaves - 1; i >= 0; i--) begin
      if ((m_addr_i & ~SlaveMask[i*AddrWidth +: AddrWidth]) ==
          SlaveBase[i*AddrWidth +: AddrWidth]) begin
        tgt = TgtW'(i);
      end
    end
  end

  assign allowed = (cnt == '0) ||
                   ((tgt == cur_tgt) && (tgt != ErrTgt) &&
                    (cnt < CntW'(MaxOutstanding)));

  always_comb begin
    s_req_o = '0;
    m_gnt_o = 1'b0;
    if (!rst && m_req_i && allowed) begin
      if (tgt == ErrTgt) begin
        m_gnt_o = 1'b1;
      end else begin
        for (int i = 0; i < NumSlaves; i++) begin
          if (tgt == TgtW'(i)) begin
            s_req_o[i] = 1'b1;
            m_gnt_o    = s_gnt_i[i];
          end
        end
      end
    end
  end

  // Responses only come from the current target; anything else is dropped.
  always_comb begin
    m_rvalid_o = 1'b0;
    m_err_o    = 1'b0;
    m_rdata_o  = '0;
    if (!rst) begin
      if (cur_tgt == ErrTgt) begin
        m_rvalid_o = err_pending;
        m_err_o    = 1'b1;
      end else begin
        for (int i = 0; i < NumSlaves; i++) begin
          if (cur_tgt == TgtW'(i)) begin
            m_rvalid_o = (cnt != '0) && s_rvalid_i[i];
            m_err_o    = s_err_i[i];
            m_rdata_o  = s_rdata_i[i*DataWidth +: DataWidth];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      cur_tgt     <= '0;
      err_pending <= 1'b0;
    end else begin
      if (m_gnt_o) begin
        cur_tgt <= tgt;
      end
      if (m_gnt_o && !m_rvalid_o) begin
        cnt <= cnt + CntW'(1);
      end else if (!m_gnt_o && m_rvalid_o) begin
        cnt <= cnt - CntW'(1);
      end
      if (m_gnt_o && (tgt == ErrTgt)) begin
        err_pending <= 1'b1;
      end else if (m_rvalid_o && (cur_tgt == ErrTgt)) begin
        err_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_demux.sv
// Directed bench for data_bus_demux; a negedge monitor pops expected responses
// from a scoreboard queue filled when requests are issued.
module tb_data_bus_demux;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            m_req_i;
  logic            m_gnt_o;
  logic [AW-1:0]   m_addr_i;
  logic            m_we_i;
  logic [DW/8-1:0] m_be_i;
  logic [DW-1:0]   m_wdata_i;
  logic            m_rvalid_o;
  logic [DW-1:0]   m_rdata_o;
  logic            m_err_o;
  logic [N-1:0]    s_req_o;
  logic [N*AW-1:0] s_addr_o;
  logic            s_we_o;
  logic [DW/8-1:0] s_be_o;
  logic [DW-1:0]   s_wdata_o;
  logic [N-1:0]    s_gnt_i;
  logic [N-1:0]    s_rvalid_i;
  logic [N*DW-1:0] s_rdata_i;
  logic [N-1:0]    s_err_i;
  logic [1:0]      outstanding_o;

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];

  int req_tbl [10];
  int gnt_tbl [10];
  int rv_tbl  [10];
  int out_tbl [10];
  int sreq_tbl[10];
  int addr_tbl[10];

  data_bus_demux #(
    .NumSlaves(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(2),
    .SlaveBase({32'h2000_0000, 32'h0010_0000, 32'h0000_0000}),
    .SlaveMask({32'h0000_0FFF, 32'h000F_FFFF, 32'h000F_FFFF})
  ) dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o),
    .m_rdata_o(m_rdata_o), .m_err_o(m_err_o), .s_req_o(s_req_o),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .s_err_i(s_err_i), .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Non-responding slaves carry distinct junk data so a wrong mux select shows up.
  task automatic apply_stimulus(input logic req, input logic [31:0] addr,
                                input logic [2:0] rv, input logic [31:0] rdata);
    m_req_i    = req;
    m_addr_i   = addr;
    s_rvalid_i = rv;
    for (int i = 0; i < N; i++)
      s_rdata_i[i*DW +: DW] = rv[i] ? rdata : (32'hBAD0_0000 | 32'(i));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && m_rvalid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_rvalid: got rdata %0h err %0b, required no response",
                 m_rdata_o, m_err_o);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        if ({m_rdata_o, m_err_o} !== e) begin
          errors++;
          $display("[TB] FAIL response: got rdata %0h err %0b, required rdata %0h err %0b",
                   m_rdata_o, m_err_o, e[DW:1], e[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    m_we_i = 1'b0;
    m_be_i = 4'hF;
    m_wdata_i = 32'h1234_5678;
    s_gnt_i = 3'b111;
    s_err_i = 3'b000;
    apply_stimulus(1'b1, 32'h0010_0040, 3'b111, 32'h1111_1111);

    // Reset defaults
    @(negedge clk);
    check_output("rst_gnt", 64'(m_gnt_o), 64'd0);
    check_output("rst_sreq", 64'(s_req_o), 64'd0);
    check_output("rst_rvalid", 64'(m_rvalid_o), 64'd0);
    check_output("rst_err", 64'(m_err_o), 64'd0);
    check_output("rst_outstanding", 64'(outstanding_o), 64'd0);
    next_cycle();
    rst = 1'b0;
    apply_stimulus(1'b0, 32'h0, 3'b000, 32'h0);
    next_cycle();

    // Decode and local address
    $display("[TB] decode and local address");
    apply_stimulus(1'b1, 32'h0010_0040, 3'b000, 32'h0);
    exp_q.push_back({32'hDEAD_BEEF, 1'b0});
    @(negedge clk);
    check_output("dec_sreq", 64'(s_req_o), 64'b010);
    check_output("dec_gnt", 64'(m_gnt_o), 64'd1);
    check_output("dec_addr0", 64'(s_addr_o[31:0]), 64'h0010_0040);
    check_output("dec_addr1", 64'(s_addr_o[63:32]), 64'h40);
    check_output("dec_addr2", 64'(s_addr_o[95:64]), 64'hE010_0040);
    check_output("dec_wdata", 64'(s_wdata_o), 64'h1234_5678);
    check_output("dec_be", 64'(s_be_o), 64'hF);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 3'b010, 32'hDEAD_BEEF);
    @(negedge clk);
    check_output("dec_rvalid", 64'(m_rvalid_o), 64'd1);
    check_output("dec_rdata", 64'(m_rdata_o), 64'hDEAD_BEEF);
    check_output("dec_outstanding", 64'(outstanding_o), 64'd1);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 3'b000, 32'h0);

    // Pipelining limit: slave 0 answers 3 cycles after each grant
    $display("[TB] pipelining limit");
    req_tbl = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    gnt_tbl = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    rv_tbl  = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    out_tbl = '{0, 1, 2, 2, 1, 1, 2, 2, 1, 0};
    for (int k = 1; k <= 4; k++) exp_q.push_back({32'hA000_0000 + 32'(k), 1'b0});
    begin
      int rsp;
      rsp = 0;
      for (int c = 0; c < 10; c++) begin
        if (rv_tbl[c] != 0) rsp++;
        apply_stimulus(req_tbl[c] != 0, 32'h0000_0010, (rv_tbl[c] != 0) ? 3'b001 : 3'b000,
                       32'hA000_0000 + 32'(rsp));
        @(negedge clk);
        check_output($sformatf("pipe_gnt_c%0d", c), 64'(m_gnt_o), 64'(gnt_tbl[c]));
        check_output($sformatf("pipe_out_c%0d", c), 64'(outstanding_o), 64'(out_tbl[c]));
        next_cycle();
      end
    end

    // Target switch stall: slave 2 waits for slave 0 to drain
    $display("[TB] target switch stall");
    req_tbl  = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    addr_tbl = '{32'h0000_0020, 32'h2000_0004, 32'h2000_0004, 32'h2000_0004,
                 32'h2000_0004, 0, 0, 0, 0, 0};
    sreq_tbl = '{3'b001, 0, 0, 0, 3'b100, 0, 0, 0, 0, 0};
    gnt_tbl  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    rv_tbl   = '{0, 0, 0, 3'b001, 0, 3'b100, 0, 0, 0, 0};
    out_tbl  = '{0, 1, 1, 1, 0, 1, 0, 0, 0, 0};
    exp_q.push_back({32'hB000_0000, 1'b0});
    exp_q.push_back({32'hC000_0000, 1'b0});
    for (int c = 0; c < 6; c++) begin
      apply_stimulus(req_tbl[c] != 0, 32'(addr_tbl[c]), 3'(rv_tbl[c]),
                     (c == 3) ? 32'hB000_0000 : 32'hC000_0000);
      @(negedge clk);
      check_output($sformatf("sw_sreq_c%0d", c), 64'(s_req_o), 64'(sreq_tbl[c]));
      check_output($sformatf("sw_gnt_c%0d", c), 64'(m_gnt_o), 64'(gnt_tbl[c]));
      check_output($sformatf("sw_out_c%0d", c), 64'(outstanding_o), 64'(out_tbl[c]));
      if (c == 4) check_output("sw_addr2", 64'(s_addr_o[95:64]), 64'h4);
      next_cycle();
    end

    // Unmapped address: internal error response, one miss every 2 cycles
    $display("[TB] unmapped address");
    req_tbl = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    gnt_tbl = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    rv_tbl  = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    exp_q.push_back({32'h0, 1'b1});
    exp_q.push_back({32'h0, 1'b1});
    for (int c = 0; c < 5; c++) begin
      apply_stimulus(req_tbl[c] != 0, 32'h8000_0000, 3'b000, 32'h0);
      @(negedge clk);
      check_output($sformatf("miss_gnt_c%0d", c), 64'(m_gnt_o), 64'(gnt_tbl[c]));
      check_output($sformatf("miss_sreq_c%0d", c), 64'(s_req_o), 64'd0);
      check_output($sformatf("miss_rvalid_c%0d", c), 64'(m_rvalid_o), 64'(rv_tbl[c]));
      if (rv_tbl[c] != 0) begin
        check_output($sformatf("miss_err_c%0d", c), 64'(m_err_o), 64'd1);
        check_output($sformatf("miss_rdata_c%0d", c), 64'(m_rdata_o), 64'd0);
      end
      next_cycle();
    end

    // Spurious response from a non-current slave, then reset with two in flight
    $display("[TB] spurious response and mid-flight reset");
    exp_q.push_back({32'hE000_0001, 1'b0});
    exp_q.push_back({32'hE000_0002, 1'b0});
    apply_stimulus(1'b1, 32'h0000_0000, 3'b000, 32'h0);
    @(negedge clk);
    check_output("mid_gnt0", 64'(m_gnt_o), 64'd1);
    next_cycle();
    @(negedge clk);
    check_output("mid_gnt1", 64'(m_gnt_o), 64'd1);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 3'b010, 32'h5555_5555);
    @(negedge clk);
    check_output("spur_rvalid", 64'(m_rvalid_o), 64'd0);
    check_output("spur_out", 64'(outstanding_o), 64'd2);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 3'b000, 32'h0);
    @(negedge clk);
    check_output("spur_out_after", 64'(outstanding_o), 64'd2);
    next_cycle();
    rst = 1'b1;
    exp_q.delete();
    apply_stimulus(1'b1, 32'h0, 3'b001, 32'h7777_7777);
    #1;
    check_output("mid_rst_out", 64'(outstanding_o), 64'd0);
    check_output("mid_rst_gnt", 64'(m_gnt_o), 64'd0);
    check_output("mid_rst_rvalid", 64'(m_rvalid_o), 64'd0);
    next_cycle();
    rst = 1'b0;
    apply_stimulus(1'b0, 32'h0, 3'b001, 32'h7777_7777);
    @(negedge clk);
    check_output("late_rvalid", 64'(m_rvalid_o), 64'd0);
    check_output("late_out", 64'(outstanding_o), 64'd0);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 3'b000, 32'h0);
    @(negedge clk);
    check_output("late_out_after", 64'(outstanding_o), 64'd0);

    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
